chip_bus_modport: RTL and testbench
===================================

CHIP_BUS_MODPORT -- requirements
Module: chip_bus_modport

Interface
REQ-001 Parameter ADDR_W, default 64, address width.
REQ-002 Parameter DATA_W, default 64, data width.
REQ-003 Parameter TIMEOUT, default 16, max cycles awaiting s_ready (range 1..255).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 m_request  input  1  master transfer request.
REQ-007 m_address  input  ADDR_W  master address.
REQ-008 m_data  input  DATA_W  master write data.
REQ-009 m_parity  input  1  even-parity bit for m_data.
REQ-010 grant  output  1  one-cycle pulse: request accepted.
REQ-011 ready  output  1  one-cycle pulse: transfer completed by slave.
REQ-012 s_request  output  1  request to slave, held until completion or timeout.
REQ-013 s_address  output  ADDR_W  latched address to slave.
REQ-014 s_data  output  DATA_W  latched data to slave.
REQ-015 s_ready  input  1  slave completion.
REQ-016 parity_err  output  1  one-cycle pulse: request rejected on parity.
REQ-017 timeout_err  output  1  one-cycle pulse: slave timed out.
REQ-018 err_count  output  8  saturating count of parity and timeout errors.

Function
REQ-019 Parity check (the "check" function) SHALL pass when XOR of all m_data bits XOR m_parity equals 0.
REQ-020 FSM states SHALL be IDLE, GRANT, BUSY; all outputs registered.
REQ-021 m_request SHALL be sampled only in IDLE; ignored in GRANT/BUSY.
REQ-022 IDLE, m_request=1, parity passes: next state GRANT; grant=1, s_request=1; s_address/s_data load m_address/m_data; timeout counter clears.
REQ-023 IDLE, m_request=1, parity fails: stay IDLE; parity_err=1 for one cycle; no grant; s_address/s_data unchanged; err_count increments.
REQ-024 GRANT SHALL last exactly one cycle; grant returns to 0 on the following edge.
REQ-025 In GRANT or BUSY, s_ready sampled 1: ready=1 for one cycle, s_request=0, next state IDLE.
REQ-026 In GRANT or BUSY, s_ready sampled 0: timeout counter increments; next state BUSY.
REQ-027 When the counter reaches TIMEOUT with s_ready=0: timeout_err=1 for one cycle, s_request=0, next state IDLE, err_count increments.
REQ-028 s_ready=1 on the same edge the timeout would fire SHALL complete normally (ready wins, no timeout_err).
REQ-029 s_ready while IDLE SHALL be ignored.
REQ-030 err_count SHALL saturate at 255 and never wrap.
REQ-031 s_address/s_data SHALL hold their last loaded value until the next accepted request.
REQ-032 Latency: request sampled at edge k -> grant high after edge k; earliest ready after edge k+1; next request accepted no earlier than edge k+2 (the edge ending the ready cycle).

Reset
REQ-033 resetN=0 SHALL immediately, independent of clock, force state IDLE, grant=0, ready=0, s_request=0, parity_err=0, timeout_err=0, err_count=0, s_address=0, s_data=0, timeout counter=0.
REQ-034 Reset asserted mid-transfer SHALL abort it with no ready or timeout_err pulse.
REQ-035 After resetN deasserts, the first rising edge SHALL operate normally from IDLE.

Verification
REQ-036 m_request=1, m_address=0x1000, m_data=0x1 with m_parity=1 -> grant pulse, s_address=0x1000, s_data=0x1, s_request=1; s_ready=1 two cycles later -> ready pulse, s_request=0.
REQ-037 m_data=0x3, m_parity=1 -> parity_err pulse, no grant, err_count=1.
REQ-038 Valid request, s_ready held 0 -> timeout_err pulse after TIMEOUT=16 cycles, s_request drops, err_count increments.
REQ-039 s_ready asserted on the exact timeout edge -> ready pulse, no timeout_err.
REQ-040 resetN pulsed low while BUSY -> all outputs 0 immediately; a new request after release is granted.
REQ-041 260 consecutive parity failures -> err_count stops at 255.

Source files
------------

// File: rtl/chip_bus_modport.sv
// Single-master to single-slave bus bridge: parity-checked request acceptance,
// slave handshake with timeout, and a saturating error counter.
module chip_bus_modport #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              m_request,
    input  logic [ADDR_W-1:0] m_address,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_parity,
    output logic              grant,
    output logic              ready,
    output logic              s_request,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_data,
    input  logic              s_ready,
    output logic              parity_err,
    output logic              timeout_err,
    output logic [7:0]        err_count
);

    // IDLE: await request | GRANT: accept cycle | BUSY: awaiting s_ready
    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] tmo_cnt;
    logic       parity_ok;
    logic [7:0] err_next;

    assign parity_ok = ~(^m_data ^ m_parity);
    assign err_next  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            tmo_cnt     <= 8'd0;
            grant       <= 1'b0;
            ready       <= 1'b0;
            s_request   <= 1'b0;
            s_address   <= '0;
            s_data      <= '0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            grant       <= 1'b0;
            ready       <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_request) begin
                        if (parity_ok) begin
                            state     <= GRANT;
                            grant     <= 1'b1;
                            s_request <= 1'b1;
                            s_address <= m_address;
                            s_data    <= m_data;
                            tmo_cnt   <= 8'd0;
                        end else begin
                            parity_err <= 1'b1;
                            err_count  <= err_next;
                        end
                    end
                end
                GRANT, BUSY: begin
                    // completion takes priority over a timeout on the same edge
                    if (s_ready) begin
                        ready     <= 1'b1;
                        s_request <= 1'b0;
                        state     <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        s_request   <= 1'b0;
                        err_count   <= err_next;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        state   <= BUSY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_bus_modport.sv
// Scoreboard bench for chip_bus_modport: stimulus queues expected output events,
// a negedge monitor pops and compares each observed pulse.
module tb_chip_bus_modport;

    logic        clock = 1'b0;
    logic        resetN;
    logic        m_request;
    logic [63:0] m_address;
    logic [63:0] m_data;
    logic        m_parity;
    logic        grant, ready, s_request, parity_err, timeout_err;
    logic [63:0] s_address, s_data;
    logic        s_ready;
    logic [7:0]  err_count;

    chip_bus_modport dut (
        .clock(clock), .resetN(resetN),
        .m_request(m_request), .m_address(m_address), .m_data(m_data), .m_parity(m_parity),
        .grant(grant), .ready(ready), .s_request(s_request),
        .s_address(s_address), .s_data(s_data), .s_ready(s_ready),
        .parity_err(parity_err), .timeout_err(timeout_err), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  flags;   // {grant, ready, parity_err, timeout_err}
        logic [63:0] addr;
        logic [63:0] data;
        logic        sreq;
        logic [7:0]  ec;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] last_addr = '0;
    logic [63:0] last_data = '0;
    logic [7:0]  ec_model = '0;

    function automatic void expect_ev(input logic [3:0] f, input logic sreq);
        exp_t e;
        e.flags = f; e.addr = last_addr; e.data = last_data; e.sreq = sreq; e.ec = ec_model;
        q.push_back(e);
    endfunction

    function automatic void bump_err();
        if (ec_model != 8'hFF) ec_model = ec_model + 8'd1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetN === 1'b1 && (grant | ready | parity_err | timeout_err)) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: flags=%b with nothing expected",
                         {grant, ready, parity_err, timeout_err});
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({grant, ready, parity_err, timeout_err} !== e.flags || s_address !== e.addr ||
                    s_data !== e.data || s_request !== e.sreq || err_count !== e.ec) begin
                    miscompares++;
                    $display("FAIL event: got flags=%b addr=%h data=%h sreq=%b ec=%0d expected flags=%b addr=%h data=%h sreq=%b ec=%0d",
                             {grant, ready, parity_err, timeout_err}, s_address, s_data, s_request, err_count,
                             e.flags, e.addr, e.data, e.sreq, e.ec);
                end
            end
        end
    end

    // All tasks begin and end just after a falling edge.
    task automatic transfer(input logic [63:0] a, input logic [63:0] d, input logic p, input int wait_n);
        last_addr = a; last_data = d;
        expect_ev(4'b1000, 1'b1);
        m_request = 1'b1; m_address = a; m_data = d; m_parity = p;
        @(negedge clock);
        m_request = 1'b0;
        repeat (wait_n) @(negedge clock);
        s_ready = 1'b1;
        expect_ev(4'b0100, 1'b0);
        @(negedge clock);
        s_ready = 1'b0;
    endtask

    task automatic bad_parity(input logic [63:0] a, input logic [63:0] d, input logic p, input int n);
        for (int i = 0; i < n; i++) begin
            bump_err();
            expect_ev(4'b0010, 1'b0);
            m_request = 1'b1; m_address = a; m_data = d; m_parity = p;
            @(negedge clock);
        end
        m_request = 1'b0;
    endtask

    task automatic timeout_run(input logic [63:0] a, input logic [63:0] d);
        last_addr = a; last_data = d;
        expect_ev(4'b1000, 1'b1);
        m_request = 1'b1; m_address = a; m_data = d; m_parity = ^d;
        @(negedge clock);
        m_request = 1'b0;
        s_ready = 1'b0;
        bump_err();
        expect_ev(4'b0001, 1'b0);
        repeat (15) @(negedge clock);
        chk("tmo_not_early_sreq", {63'd0, s_request}, 64'd1);
        chk("tmo_not_early_err", {63'd0, timeout_err}, 64'd0);
        @(negedge clock);
        chk("tmo_fires", {63'd0, timeout_err}, 64'd1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        resetN = 1'b0; m_request = 1'b0; m_address = '0; m_data = '0; m_parity = 1'b0; s_ready = 1'b0;
        #1;
        chk("rst_outputs", {grant, ready, s_request, parity_err, timeout_err}, 64'd0);
        chk("rst_err_count", {56'd0, err_count}, 64'd0);
        chk("rst_s_address", s_address, 64'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        transfer(64'h1000, 64'h1, 1'b1, 1);
        bad_parity(64'h2000, 64'h3, 1'b1, 1);
        chk("parity_err_count", {56'd0, err_count}, 64'd1);
        transfer(64'hABCD_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        timeout_run(64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF);
        transfer(64'h5555, 64'h7, 1'b1, 15);
        bad_parity(64'h9999, 64'h8, 1'b0, 1);

        // s_ready while idle must not produce any event
        s_ready = 1'b1;
        repeat (3) @(negedge clock);
        s_ready = 1'b0;
        @(negedge clock);

        // reset while BUSY aborts the transfer
        last_addr = 64'h4242; last_data = 64'h3;
        expect_ev(4'b1000, 1'b1);
        m_request = 1'b1; m_address = 64'h4242; m_data = 64'h3; m_parity = 1'b0;
        @(negedge clock);
        m_request = 1'b0;
        repeat (3) @(negedge clock);
        #2 resetN = 1'b0;
        #1;
        chk("midrst_outputs", {grant, ready, s_request, parity_err, timeout_err}, 64'd0);
        chk("midrst_err_count", {56'd0, err_count}, 64'd0);
        chk("midrst_s_data", s_data, 64'd0);
        last_addr = '0; last_data = '0; ec_model = '0;
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        chk("midrst_no_pulse", {60'd0, grant, ready, parity_err, timeout_err}, 64'd0);
        transfer(64'h7777, 64'h10, 1'b1, 2);

        bad_parity(64'h1, 64'h1, 1'b0, 260);
        chk("err_saturate", {56'd0, err_count}, 64'd255);

        repeat (5) @(negedge clock);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
